// File: rtl/database_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// database_request_arbiter_if
//
// Bundles the engine-side and reader-side signals of the database request
// arbiter. The arbiter connects through the master modport. The engines and
// the shared stage-database reader connect through the slave modport.
//
// Handshake semantics (one rule for the whole bundle):
//   - request[i] is a level. Engine i keeps it high for as long as it wants
//     the reader. Dropping it while owning ends the grant.
//   - inspect_done[i] is a single-cycle pulse. It only matters from the
//     current owner.
//   - db_ready qualifies db_data for exactly the cycle it is high. There is no
//     backpressure: a word is either taken that cycle or lost.
//   - o_data_valid[i] qualifies o_data toward engine i for exactly one cycle.
//     At most one bit is ever set.
//
// Signals:
//   request, inspect_done  : engine -> arbiter, one bit per engine
//   db_ready, db_data      : reader -> arbiter
//   o_grant, o_owner       : one-hot grant and owner index
//   o_db_restart           : one-cycle pointer rewind pulse to the reader
//   o_db_enable            : reader enable
//   o_data, o_data_valid   : forwarded word and one-hot qualifier
//   o_busy, o_timeout      : status
//   dbg_state              : FSM state (0 IDLE, 1 RESTART, 2 SERVE, 3 RELEASE)
// -----------------------------------------------------------------------------
interface database_request_arbiter_if #(
  parameter int NUM_ENGINE    = 4,
  parameter int DATA_WIDTH_16 = 16,
  parameter int OWNER_WIDTH   = 2
);
  logic [NUM_ENGINE-1:0]    request;
  logic [NUM_ENGINE-1:0]    inspect_done;
  logic                     db_ready;
  logic [DATA_WIDTH_16-1:0] db_data;
  logic [NUM_ENGINE-1:0]    o_grant;
  logic [OWNER_WIDTH-1:0]   o_owner;
  logic                     o_db_restart;
  logic                     o_db_enable;
  logic [DATA_WIDTH_16-1:0] o_data;
  logic [NUM_ENGINE-1:0]    o_data_valid;
  logic                     o_busy;
  logic                     o_timeout;
  logic [1:0]               dbg_state;

  modport master (
    input  request, inspect_done, db_ready, db_data,
    output o_grant, o_owner, o_db_restart, o_db_enable,
           o_data, o_data_valid, o_busy, o_timeout, dbg_state
  );

  modport slave (
    output request, inspect_done, db_ready, db_data,
    input  o_grant, o_owner, o_db_restart, o_db_enable,
           o_data, o_data_valid, o_busy, o_timeout, dbg_state
  );
endinterface

// File: rtl/database_request_arbiter.sv
// -----------------------------------------------------------------------------
// database_request_arbiter
//
// Round-robin arbiter that shares one stage-database reader among NUM_ENGINE
// scale engines. Each grant starts with a one-cycle pointer rewind (RESTART).
// During SERVE, reader words are forwarded to the owner only. The grant is
// released on the owner's inspect_done or when the owner drops its request.
// After a release, the search for the next owner starts one position past the
// engine that just finished.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; drops any grant immediately
//   bus    : database_request_arbiter_if.master (see interface header)
//
// Optional feature, enabled by the macro ARB_TIMEOUT_EN:
//   A grant is forcibly released after MAX_HOLD SERVE cycles, and o_timeout
//   pulses together with the grant drop. Without the macro, o_timeout is
//   always 0 and a grant may be held indefinitely.
// -----------------------------------------------------------------------------
module database_request_arbiter #(
  parameter int NUM_ENGINE    = 4,
  parameter int DATA_WIDTH_16 = 16,
  parameter int OWNER_WIDTH   = 2,
  parameter int MAX_HOLD      = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  database_request_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTART = 2'd1,
    S_SERVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_ENGINE-1:0]    grant_q, grant_d;
  logic [OWNER_WIDTH-1:0]   owner_q, owner_d;
  logic [OWNER_WIDTH-1:0]   last_q, last_d;
  logic                     restart_q, restart_d;
  logic                     enable_q, enable_d;
  logic [DATA_WIDTH_16-1:0] data_q, data_d;
  logic [NUM_ENGINE-1:0]    valid_q, valid_d;
  logic                     timeout_q, timeout_d;

  logic                     sel_found;
  logic [OWNER_WIDTH-1:0]   sel_idx;
  logic [OWNER_WIDTH-1:0]   cand;
  logic                     owner_release;
  logic                     timeout_hit;
  logic                     release_now;

  // Rotating-priority search: the first requester at or above last_owner+1,
  // wrapping modulo NUM_ENGINE. The last owner is visited last, so a busy
  // engine cannot starve the others.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_ENGINE; i++) begin
      cand = OWNER_WIDTH'((int'(last_q) + i) % NUM_ENGINE);
      if (!sel_found && bus.request[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Only the owner's done/request bits can end a grant. Any other engine's
  // bits are ignored here.
  assign owner_release = bus.inspect_done[owner_q] | ~bus.request[owner_q];
  assign release_now   = owner_release | timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;

  // hold_q holds the number of SERVE cycles already completed. While it
  // equals MAX_HOLD-1, the current cycle is the MAX_HOLD-th SERVE cycle.
  assign timeout_hit = (state_q == S_SERVE) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == S_RESTART) begin
      hold_d = '0;
    end else if (state_q == S_SERVE) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Feature compiled out. A non-positive limit is meaningless, so this is
  // constant 0 for every legal MAX_HOLD.
  assign timeout_hit = (MAX_HOLD < 0);
`endif

  // State register together with the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= OWNER_WIDTH'(NUM_ENGINE - 1);
      restart_q <= 1'b0;
      enable_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      restart_q <= restart_d;
      enable_q  <= enable_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sel_found) state_d = S_RESTART;
      S_RESTART: state_d = S_SERVE;
      S_SERVE:   if (release_now) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    restart_d = 1'b0;
    enable_d  = enable_q;
    data_d    = data_q;
    valid_d   = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d   = NUM_ENGINE'(1) << sel_idx;
          owner_d   = sel_idx;
          restart_d = 1'b1;
        end
      end
      S_RESTART: begin
        enable_d = 1'b1;
      end
      S_SERVE: begin
        // grant_q is still the owner's bit in the release cycle, so a word
        // arriving together with the release is still delivered.
        if (bus.db_ready) begin
          data_d  = bus.db_data;
          valid_d = grant_q;
        end
        if (release_now) begin
          grant_d   = '0;
          enable_d  = 1'b0;
          timeout_d = timeout_hit & ~owner_release;
        end
      end
      S_RELEASE: begin
        last_d = owner_q;
      end
      default: ;
    endcase
  end

  assign bus.o_grant      = grant_q;
  assign bus.o_owner      = owner_q;
  assign bus.o_db_restart = restart_q;
  assign bus.o_db_enable  = enable_q;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_busy       = (state_q != S_IDLE);
  assign bus.o_timeout    = timeout_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_database_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_database_request_arbiter
//
// Directed cases followed by randomized traffic for database_request_arbiter.
// The driver applies inputs one cycle at a time, just after the falling edge.
// On each cycle it advances a transaction-level reference model and pushes the
// expected outputs:
//   - ctl_q : expected control outputs for every clock edge
//   - exp_q : expected {valid mask, word} for every forwarded word
// At each falling edge, the monitor pops from these queues and compares them
// with the DUT outputs.
// The reference model tracks the current holder, the age of its grant and
// the turnaround gap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_database_request_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int HOLD  = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int HOLD  = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [OW-1:0] owner;
    logic          restart;
    logic          enable;
    logic          busy;
    logic          timeout;
    logic [N-1:0]  valid;
  } ctl_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  database_request_arbiter_if #(.NUM_ENGINE(N), .DATA_WIDTH_16(DW), .OWNER_WIDTH(OW)) bus ();

  database_request_arbiter #(
    .NUM_ENGINE(N), .DATA_WIDTH_16(DW), .OWNER_WIDTH(OW), .MAX_HOLD(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;
  logic          mon_en = 1'b0;
  ctl_t          ctl_q[$];
  logic [N+DW-1:0] exp_q[$];
  logic [OW-1:0] grant_log[$];
  int            timeout_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  int m_holder;    // engine holding the reader, -1 when none
  int m_age;       // 0 on the grant edge, then n on the n-th SERVE edge
  int m_cool;      // edges left before arbitration may happen again
  int m_last;      // engine that finished most recently
  int m_owner_out; // value o_owner should show
  int m_words;     // words delivered in the current grant

  task automatic model_reset();
    m_holder    = -1;
    m_age       = 0;
    m_cool      = 0;
    m_last      = N - 1;
    m_owner_out = 0;
    m_words     = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] done,
                            input logic rdy, input logic [DW-1:0] data);
    ctl_t e;
    int   w;
    bit   found;
    e = '0;
    if (m_holder >= 0) begin
      if (m_age == 0) begin
        m_age = 1;
      end else begin
        if (rdy) begin
          e.valid = N'(1) << m_holder;
          exp_q.push_back({e.valid, data});
          m_words++;
        end
        if (done[m_holder] || !req[m_holder]) begin
          m_last = m_holder; m_holder = -1; m_cool = 1;
        end else if (TO_EN && m_age == HOLD) begin
          e.timeout = 1'b1;
          m_last = m_holder; m_holder = -1; m_cool = 1;
        end else begin
          m_age++;
        end
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req != '0) begin
      found = 1'b0;
      w = 0;
      for (int i = 1; i <= N; i++) begin
        if (!found && req[(m_last + i) % N]) begin
          found = 1'b1;
          w = (m_last + i) % N;
        end
      end
      m_holder = w; m_age = 0; m_words = 0; m_owner_out = w;
      e.restart = 1'b1;
    end
    if (m_holder >= 0) e.grant = N'(1) << m_holder;
    e.enable = (m_holder >= 0) && (m_age >= 1);
    e.busy   = (m_holder >= 0) || (m_cool > 0);
    e.owner  = OW'(m_owner_out);
    ctl_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_cycle(input logic [N-1:0] req, input logic [N-1:0] done,
                             input logic rdy, input logic [DW-1:0] data);
    bus.request      = req;
    bus.inspect_done = done;
    bus.db_ready     = rdy;
    bus.db_data      = data;
    model_step(req, done, rdy, data);
    mon_en = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic zero_inputs();
    bus.request      = '0;
    bus.inspect_done = '0;
    bus.db_ready     = 1'b0;
    bus.db_data      = '0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    zero_inputs();
    reset = 1'b1;
    ctl_q.delete();
    exp_q.delete();
    model_reset();
    repeat (2) begin @(negedge clk); #1; end
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  function automatic logic [N-1:0] owner_done_after(input int words);
    if (m_holder >= 0 && m_age >= 1 && m_words >= words) return N'(1) << m_holder;
    return '0;
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : monitor
    ctl_t e;
    logic [N+DW-1:0] x;
    if (mon_en && !reset) begin
      if (ctl_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL ctl_q: no expected entry at %0t", $time);
      end else begin
        e = ctl_q.pop_front();
        check("o_grant",      bus.o_grant,      e.grant);
        check("o_owner",      bus.o_owner,      e.owner);
        check("o_db_restart", bus.o_db_restart, e.restart);
        check("o_db_enable",  bus.o_db_enable,  e.enable);
        check("o_busy",       bus.o_busy,       e.busy);
        check("o_timeout",    bus.o_timeout,    e.timeout);
        check("o_data_valid", bus.o_data_valid, e.valid);
      end
      if (bus.o_db_restart) grant_log.push_back(bus.o_owner);
      if (bus.o_timeout) timeout_seen++;
      if (bus.o_data_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL exp_q: unexpected word 0x%0h valid 0x%0h", bus.o_data, bus.o_data_valid);
        end else begin
          x = exp_q.pop_front();
          check("word_valid", bus.o_data_valid, x[N+DW-1:DW]);
          check("word_data",  bus.o_data,       x[DW-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stim
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [DW-1:0] d;
    int            exp_order[5];

    // Reset state, then a single requester (engine 2).
    reset = 1'b1;
    zero_inputs();
    model_reset();
    repeat (2) begin @(negedge clk); #1; end
    check("rst_grant",   bus.o_grant,      0);
    check("rst_owner",   bus.o_owner,      0);
    check("rst_restart", bus.o_db_restart, 0);
    check("rst_enable",  bus.o_db_enable,  0);
    check("rst_data",    bus.o_data,       0);
    check("rst_valid",   bus.o_data_valid, 0);
    check("rst_busy",    bus.o_busy,       0);
    check("rst_timeout", bus.o_timeout,    0);
    check("rst_state",   bus.dbg_state,    0);
    reset = 1'b0;
    @(negedge clk); #1;
    repeat (2) drive_cycle('0, '0, 1'b0, '0);
    drive_cycle(4'b0100, '0, 1'b0, '0);
    check("t1_grant",   bus.o_grant,      4'b0100);
    check("t1_restart", bus.o_db_restart, 1);
    check("t1_enable0", bus.o_db_enable,  0);
    drive_cycle(4'b0100, '0, 1'b0, '0);
    check("t1_enable1", bus.o_db_enable,  1);
    check("t1_restart0", bus.o_db_restart, 0);
    repeat (3) drive_cycle('0, '0, 1'b0, '0);

    // All four requesting; each owner finishes after three words.
    do_reset();
    grant_log.delete();
    repeat (32) drive_cycle(4'b1111, owner_done_after(3), 1'b1, DW'($urandom_range(65535, 0)));
    repeat (3) drive_cycle('0, '0, 1'b0, '0);
    exp_order = '{0, 1, 2, 3, 0};
    check("t2_order_len", (grant_log.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("t2_order", grant_log[i], exp_order[i]);
    end

    // Forwarding a single word to owner 1.
    do_reset();
    repeat (2) drive_cycle(4'b0010, '0, 1'b0, '0);
    drive_cycle(4'b0010, '0, 1'b1, 16'hA5C3);
    check("t3_data",  bus.o_data,       16'hA5C3);
    check("t3_valid", bus.o_data_valid, 4'b0010);
    drive_cycle(4'b0010, '0, 1'b0, 16'h1111);
    check("t3_valid_drop", bus.o_data_valid, 0);
    repeat (3) drive_cycle('0, '0, 1'b0, '0);

    // Non-owner done is ignored; owner done together with a word.
    do_reset();
    repeat (2) drive_cycle(4'b0100, '0, 1'b0, '0);
    drive_cycle(4'b0100, 4'b1000, 1'b0, '0);
    check("t4_nonowner_done", bus.o_grant, 4'b0100);
    drive_cycle(4'b0100, 4'b0100, 1'b1, 16'h0042);
    check("t4_grant_drop", bus.o_grant,      0);
    check("t4_data",       bus.o_data,       16'h0042);
    check("t4_valid",      bus.o_data_valid, 4'b0100);
    repeat (2) drive_cycle('0, '0, 1'b0, '0);

    // Reset in the middle of SERVE (owner 3).
    do_reset();
    repeat (3) drive_cycle(4'b1000, '0, 1'b0, '0);
    mon_en = 1'b0;
    zero_inputs();
    reset = 1'b1;
    #1;
    check("t5_async_grant",  bus.o_grant,     0);
    check("t5_async_enable", bus.o_db_enable, 0);
    check("t5_async_busy",   bus.o_busy,      0);
    ctl_q.delete();
    exp_q.delete();
    model_reset();
    repeat (2) begin @(negedge clk); #1; end
    reset = 1'b0;
    drive_cycle(4'b1000, '0, 1'b0, '0);
    check("t5_regrant",  bus.o_grant,      4'b1000);
    check("t5_restart",  bus.o_db_restart, 1);
    drive_cycle(4'b1000, '0, 1'b0, '0);
    repeat (3) drive_cycle('0, '0, 1'b0, '0);

`ifdef ARB_TIMEOUT_EN
    // Forced release of an owner that never finishes.
    do_reset();
    grant_log.delete();
    timeout_seen = 0;
    repeat (12) drive_cycle(4'b0011, '0, 1'(($urandom_range(1, 0))), DW'($urandom_range(65535, 0)));
    check("t6_timeouts", timeout_seen, 1);
    check("t6_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("t6_first",  grant_log[0], 0);
      check("t6_second", grant_log[1], 1);
    end
    repeat (3) drive_cycle('0, '0, 1'b0, '0);
`endif

    // Randomized traffic.
    do_reset();
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(15, 0) == 0) req[b] = ~req[b];
      end
      done = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7, 0) == 0) done[b] = 1'b1;
      end
      if (m_holder >= 0 && $urandom_range(5, 0) == 0) done = done | (N'(1) << m_holder);
      d = DW'($urandom_range(65535, 0));
      drive_cycle(req, done, 1'($urandom_range(1, 0)), d);
    end
    repeat (4) drive_cycle('0, '0, 1'b0, '0);

    check("ctl_q_left", ctl_q.size(), 0);
    check("exp_q_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
